serial_compare_ctrl: RTL and testbench

//  Sequencer for the 1-bit comparator cell. Compares two WIDTH-bit unsigned

---
 rtl/serial_compare_ctrl_pkg.sv | 24 ++
 rtl/serial_compare_ctrl_cell.sv | 15 +
 rtl/serial_compare_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_compare_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_compare_ctrl_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encoding, result flag bit positions and a counter sizing helper.
package serial_compare_ctrl_pkg;

    // Sequencer states; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result flags are kept as one vector ordered {greater, lesser, equal}.
    typedef logic [2:0] flags_t;

    localparam int FLAG_GT = 2;
    localparam int FLAG_LT = 1;
    localparam int FLAG_EQ = 0;

    // Width of the bit counter; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_compare_ctrl_cell.sv
// Single-bit magnitude compare cell. Purely combinational; the sequencer
// feeds it one bit pair per clock, MSB first.
module bit_compare_cell (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);

    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator sequencer.
// Captures two operands on an accepted start, walks them MSB first through
// one shared bit_compare_cell and reports registered greater/lesser/equal
// flags together with a one-cycle done pulse. With EARLY_EXIT set, the run
// stops at the first differing bit; otherwise all WIDTH bits are visited and
// the first difference is remembered in a sticky register.
module serial_compare_ctrl
    import serial_compare_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             lesser,
    output logic             equal
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic [1:0]       sticky;
    flags_t           flags;
    logic             busy_q;
    logic             done_q;

    logic             cell_gt;
    logic             cell_lt;
    logic             cell_eq;
    logic             bit_diff;
    logic [1:0]       sticky_next;
    flags_t           final_flags;

    // The only compare cell: it always looks at the current MSBs of the
    // operand shift registers.
    bit_compare_cell u_cell (
        .a  (a_sr[WIDTH-1]),
        .b  (b_sr[WIDTH-1]),
        .gt (cell_gt),
        .lt (cell_lt),
        .eq (cell_eq)
    );

    // Sticky first-difference tracking and the flags reported when the last
    // bit has been visited. Only the first differing bit may set the sticky
    // register; later differences are lower significance and are ignored.
    always_comb begin
        bit_diff    = ~cell_eq;
        sticky_next = sticky;
        if (bit_diff && (sticky == 2'b00)) begin
            sticky_next = {cell_gt, cell_lt};
        end
        final_flags          = '0;
        final_flags[FLAG_GT] = sticky_next[1];
        final_flags[FLAG_LT] = sticky_next[0];
        final_flags[FLAG_EQ] = (sticky_next == 2'b00);
    end

    // Sequencer: accepts a start in IDLE or DONE, runs one bit per clock in
    // RUN and pulses done for one cycle in DONE. Reset mid-run simply drops
    // the operation without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            cnt    <= '0;
            sticky <= 2'b00;
            flags  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        a_sr   <= a_in;
                        b_sr   <= b_in;
                        cnt    <= CNT_LOAD;
                        sticky <= 2'b00;
                        flags  <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (EARLY_EXIT && bit_diff) begin
                        flags          <= '0;
                        flags[FLAG_GT] <= cell_gt;
                        flags[FLAG_LT] <= cell_lt;
                        state          <= DONE;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                    end else begin
                        sticky <= sticky_next;
                        a_sr   <= a_sr << 1;
                        b_sr   <= b_sr << 1;
                        if (cnt == '0) begin
                            flags  <= final_flags;
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign greater = flags[FLAG_GT];
    assign lesser  = flags[FLAG_LT];
    assign equal   = flags[FLAG_EQ];

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl. Three instances share the
// clock and reset: 8-bit with early exit, 8-bit without early exit, and
// 1-bit with early exit. One instance is addressed at a time via 'sel'.
module tb_serial_compare_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] sel;
    logic       start_drv;
    logic [7:0] a_drv;
    logic [7:0] b_drv;

    logic busy0, done0, gt0, lt0, eq0;
    logic busy1, done1, gt1, lt1, eq1;
    logic busy2, done2, gt2, lt2, eq2;
    logic busy_s, done_s, gt_s, lt_s, eq_s;

    int checks;
    int failures;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start_drv && (sel == 2'd0)),
        .a_in(a_drv), .b_in(b_drv),
        .busy(busy0), .done(done0), .greater(gt0), .lesser(lt0), .equal(eq0)
    );

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .rst_n(rst_n), .start(start_drv && (sel == 2'd1)),
        .a_in(a_drv), .b_in(b_drv),
        .busy(busy1), .done(done1), .greater(gt1), .lesser(lt1), .equal(eq1)
    );

    serial_compare_ctrl #(.WIDTH(1), .EARLY_EXIT(1'b1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_drv && (sel == 2'd2)),
        .a_in(a_drv[0:0]), .b_in(b_drv[0:0]),
        .busy(busy2), .done(done2), .greater(gt2), .lesser(lt2), .equal(eq2)
    );

    // Outputs of the currently addressed instance.
    always_comb begin
        case (sel)
            2'd0:    {busy_s, done_s, gt_s, lt_s, eq_s} = {busy0, done0, gt0, lt0, eq0};
            2'd1:    {busy_s, done_s, gt_s, lt_s, eq_s} = {busy1, done1, gt1, lt1, eq1};
            default: {busy_s, done_s, gt_s, lt_s, eq_s} = {busy2, done2, gt2, lt2, eq2};
        endcase
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: the result is plain unsigned magnitude comparison; the
    // latency is the MSB-first position of the highest differing bit when
    // early exit is enabled, and the full width otherwise.
    function automatic void refModel(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                                     output int k, output int flags);
        int         w;
        bit         ee;
        logic [7:0] am;
        logic [7:0] bm;
        logic [7:0] x;
        w  = (s == 2'd2) ? 1 : 8;
        ee = (s != 2'd1);
        am = (s == 2'd2) ? {7'b0, a[0]} : a;
        bm = (s == 2'd2) ? {7'b0, b[0]} : b;
        flags = (am > bm) ? 4 : (am < bm) ? 2 : 1;
        k = w;
        if (ee && (am != bm)) begin
            x = am ^ bm;
            for (int i = 0; i < w; i++) begin
                if (x[i]) k = w - i;
            end
        end
    endfunction

    // Present a start request with operands on the selected instance.
    task automatic applyStimulus(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
        sel       = s;
        a_drv     = a;
        b_drv     = b;
        start_drv = 1'b1;
    endtask

    // Clock through the accept edge and the run, checking busy and cleared
    // flags each cycle, then the done latency and flags. Operands are
    // scrambled after accept; start is optionally held for some RUN cycles.
    task automatic waitDone(input string name, input int exp_k, input int exp_flags,
                            input int hold_cycles);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        checkOutput({name, " accept busy"}, int'(busy_s), 1);
        checkOutput({name, " accept flags"}, int'({gt_s, lt_s, eq_s}), 0);
        start_drv = (hold_cycles > 0);
        a_drv = 8'($urandom);
        b_drv = 8'($urandom);
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(posedge clk); #1;
            if (done_s) begin
                seen = 1'b1;
                checkOutput({name, " latency"}, cyc, exp_k);
                checkOutput({name, " flags"}, int'({gt_s, lt_s, eq_s}), exp_flags);
                checkOutput({name, " busy at done"}, int'(busy_s), 0);
            end else begin
                checkOutput({name, " run busy/flags"}, int'({busy_s, gt_s, lt_s, eq_s}), 8);
                start_drv = (cyc < hold_cycles);
                a_drv = 8'($urandom);
                b_drv = 8'($urandom);
            end
        end
        start_drv = 1'b0;
        if (!seen) checkOutput({name, " done timeout"}, 0, 1);
    endtask

    // One cycle after done: pulse gone, idle, flags still held.
    task automatic checkTail(input string name, input int exp_flags);
        @(posedge clk); #1;
        checkOutput({name, " tail done/busy"}, int'({done_s, busy_s}), 0);
        checkOutput({name, " tail flags"}, int'({gt_s, lt_s, eq_s}), exp_flags);
    endtask

    typedef struct {
        string      name;
        logic [1:0] s;
        logic [7:0] a;
        logic [7:0] b;
        int         k;
        int         flags;
        int         hold;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int         k;
        int         fl;
        logic [1:0] s;
        logic [7:0] a;
        logic [7:0] b;

        checks    = 0;
        failures  = 0;
        sel       = 2'd0;
        start_drv = 1'b0;
        a_drv     = 8'h00;
        b_drv     = 8'h00;

        // Expected flags encoded {greater,lesser,equal}: 4=gt, 2=lt, 1=eq.
        vecs[0]  = '{"eq_a5",       2'd0, 8'hA5, 8'hA5, 8, 1, 0};
        vecs[1]  = '{"ee_80_7f",    2'd0, 8'h80, 8'h7F, 1, 4, 0};
        vecs[2]  = '{"ee_12_13",    2'd0, 8'h12, 8'h13, 8, 2, 0};
        vecs[3]  = '{"ee_5a_4a",    2'd0, 8'h5A, 8'h4A, 4, 4, 0};
        vecs[4]  = '{"full_80_7f",  2'd1, 8'h80, 8'h7F, 8, 4, 0};
        vecs[5]  = '{"full_12_13",  2'd1, 8'h12, 8'h13, 8, 2, 0};
        vecs[6]  = '{"hold_start",  2'd0, 8'hA5, 8'hA5, 8, 1, 3};
        vecs[7]  = '{"w1_0_0",      2'd2, 8'h00, 8'h00, 1, 1, 0};
        vecs[8]  = '{"w1_0_1",      2'd2, 8'h00, 8'h01, 1, 2, 0};
        vecs[9]  = '{"w1_1_0",      2'd2, 8'h01, 8'h00, 1, 4, 0};
        vecs[10] = '{"w1_1_1",      2'd2, 8'h01, 8'h01, 1, 1, 0};

        // Power-up reset held for three cycles; all outputs low throughout.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            checkOutput("reset outputs", int'({busy_s, done_s, gt_s, lt_s, eq_s}), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].s, vecs[i].a, vecs[i].b);
            waitDone(vecs[i].name, vecs[i].k, vecs[i].flags, vecs[i].hold);
            checkTail(vecs[i].name, vecs[i].flags);
        end

        // Back-to-back: new start issued during the DONE cycle.
        @(negedge clk);
        applyStimulus(2'd1, 8'h3C, 8'h3C);
        waitDone("b2b_first", 8, 1, 0);
        applyStimulus(2'd1, 8'h01, 8'h02);
        waitDone("b2b_second", 8, 2, 0);
        checkTail("b2b_second", 2);

        // Randomized transactions checked against the reference model.
        for (int i = 0; i < 60; i++) begin
            s = 2'($urandom_range(0, 2));
            a = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ (8'h01 << $urandom_range(0, 7));
                default: b = 8'($urandom);
            endcase
            refModel(s, a, b, k, fl);
            @(negedge clk);
            applyStimulus(s, a, b);
            waitDone("random", k, fl, 0);
            checkTail("random", fl);
        end

        // Reset mid-run on the 8-bit instance; the 1-bit instance holds
        // flags from a finished run and must clear them asynchronously.
        @(negedge clk);
        applyStimulus(2'd2, 8'h01, 8'h00);
        waitDone("pre_reset", 1, 4, 0);
        @(negedge clk);
        applyStimulus(2'd0, 8'hC3, 8'hC3);
        @(posedge clk); #1;
        start_drv = 1'b0;
        checkOutput("midrun accepted busy", int'(busy_s), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun reset outputs", int'({busy_s, done_s, gt_s, lt_s, eq_s}), 0);
        sel = 2'd2;
        #1;
        checkOutput("midrun reset other flags", int'({busy_s, done_s, gt_s, lt_s, eq_s}), 0);
        sel = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("post reset idle", int'({busy_s, done_s}), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
